// File: rtl/gtp_tx_mux.sv
// Round-robin packet mux feeding one Aurora TX stream: channel-ID header, over-length truncation.
// Define GTP_TX_MUX_TRAILER_EN to append a trailer word (0x5A, trunc flag, payload count) to each packet.
module gtp_tx_mux #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MAX_PKT_WORDS = 256,
  parameter logic [7:0]  HDR_MAGIC     = 8'hA5
) (
  input  logic                     user_clk,
  input  logic                     reset,
  input  logic                     channel_up,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     err_trunc,
  output logic [3:0]               grant_ch
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_WORDS) + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
`ifdef GTP_TX_MUX_TRAILER_EN
  localparam logic [2:0] ST_TRL   = 3'd4;
`endif

  logic [2:0]        state;
  logic [3:0]        rr_ptr;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              at_max;
  logic              out_free;
  logic              any_req;
  logic [3:0]        next_ch;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              beat_acc;
  logic [DATA_W-1:0] hdr_word;
`ifdef GTP_TX_MUX_TRAILER_EN
  logic              trunc_flag;
  logic [DATA_W-1:0] trl_word;
`endif

  assign out_free = !m_tvalid || m_tready;
  assign cnt_inc  = word_cnt + CNT_W'(1);
  assign at_max   = (cnt_inc == CNT_W'(MAX_PKT_WORDS));
  assign beat_acc = (state == ST_DATA) && out_free && sel_valid;

  // First valid channel strictly after rr_ptr, wrapping at NUM_CH-1.
  always_comb begin
    any_req = 1'b0;
    next_ch = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!any_req && s_tvalid[j] && (j == (32'(rr_ptr) + off) % NUM_CH)) begin
          any_req = 1'b1;
          next_ch = 4'(j);
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    s_tready  = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (grant_ch == 4'(j)) begin
        sel_data    = s_tdata[j*DATA_W +: DATA_W];
        sel_valid   = s_tvalid[j];
        sel_last    = s_tlast[j];
        s_tready[j] = ((state == ST_DATA) && out_free) || (state == ST_FLUSH);
      end
    end
  end

  always_comb begin
    hdr_word                   = '0;
    hdr_word[DATA_W-1 -: 8]    = HDR_MAGIC;
    hdr_word[DATA_W-9 -: 8]    = 8'(grant_ch);
`ifdef GTP_TX_MUX_TRAILER_EN
    trl_word                   = DATA_W'(word_cnt);
    trl_word[DATA_W-1 -: 16]   = {8'h5A, 7'b0, trunc_flag};
`endif
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 4'(NUM_CH - 1);
      grant_ch  <= '0;
      word_cnt  <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      err_trunc <= 1'b0;
`ifdef GTP_TX_MUX_TRAILER_EN
      trunc_flag <= 1'b0;
`endif
    end else begin
      err_trunc <= 1'b0;
      // Drain by default; any load below overrides this.
      if (out_free) m_tvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (channel_up && any_req) begin
            grant_ch <= next_ch;
            rr_ptr   <= next_ch;
            word_cnt <= '0;
`ifdef GTP_TX_MUX_TRAILER_EN
            trunc_flag <= 1'b0;
`endif
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (out_free) begin
            m_tdata  <= hdr_word;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_acc) begin
            m_tdata  <= sel_data;
            m_tvalid <= 1'b1;
            word_cnt <= cnt_inc;
`ifdef GTP_TX_MUX_TRAILER_EN
            m_tlast  <= 1'b0;
            if (sel_last || at_max) begin
              trunc_flag <= !sel_last;
              err_trunc  <= !sel_last;
              state      <= ST_TRL;
            end
`else
            m_tlast  <= sel_last || at_max;
            if (sel_last) begin
              state <= ST_IDLE;
            end else if (at_max) begin
              err_trunc <= 1'b1;
              state     <= ST_FLUSH;
            end
`endif
          end
        end
        ST_FLUSH: begin
          if (sel_valid && sel_last) state <= ST_IDLE;
        end
`ifdef GTP_TX_MUX_TRAILER_EN
        ST_TRL: begin
          if (out_free) begin
            m_tdata  <= trl_word;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b1;
            state    <= trunc_flag ? ST_FLUSH : ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gtp_tx_mux.md
Name: gtp_tx_mux

Overview:
- Parametrised N-channel packet multiplexer that feeds one Aurora 8b10b framing TX stream (s_axi_tx_* side) from several AXI-Stream sources.
- Runs in the user_clk domain, downstream of the per-channel CDC FIFOs and upstream of the Aurora core.
- Arbitrates round-robin per packet, prefixes each packet with a channel-ID header word, and truncates over-length packets.

Parameters:
- DATA_W, 32, stream data width; legal values ≥ 16.
- NUM_CH, 4, number of input channels; legal range 2..16.
- MAX_PKT_WORDS, 256, maximum payload words per packet, header excluded; legal values ≥ 2.
- HDR_MAGIC, 8'hA5, value placed in the top byte of the header word.

Ports:
- user_clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- channel_up  in  1  Aurora link status; new grants are allowed only while it is high.
- s_tdata  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tlast  in  NUM_CH  per-channel end of packet.
- s_tready  out  NUM_CH  per-channel ready.
- m_tdata  out  DATA_W  muxed output data.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of packet.
- m_tready  in  1  Aurora s_axi_tx_tready.
- err_trunc  out  1  one-cycle pulse when a packet is truncated.
- grant_ch  out  4  index of the current or most recent granted channel.

Behaviour:
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, err_trunc=0, grant_ch=0, state=IDLE, rr pointer=NUM_CH-1.
- Output stage is registered. An output word loads when out_free = !m_tvalid || m_tready.
- While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
- Sustained throughput is 1 word per cycle.
- IDLE:
  - If channel_up=1 and any s_tvalid is set, grant the first valid channel after the rr pointer (search wraps at NUM_CH-1 → 0).
  - On grant: latch the channel into grant_ch and update the rr pointer, then go to HDR.
  - s_tready is all zero in IDLE.
- HDR:
  - When out_free, load header = {HDR_MAGIC, grant_ch zero-extended to 8 bits, zero padding to DATA_W}, with m_tlast=0, then go to DATA.
  - The header appears on m_tvalid exactly 1 cycle after the grant cycle.
- DATA:
  - s_tready[grant_ch] = out_free; all other s_tready bits are 0.
  - Each accepted beat loads into the output register and increments a word counter (width clog2(MAX_PKT_WORDS)+1, cleared on grant).
  - If an accepted beat has s_tlast=1: m_tlast=1, go to IDLE.
  - If the counter reaches MAX_PKT_WORDS on an accepted beat and s_tlast=0: force m_tlast=1, pulse err_trunc for that cycle, go to FLUSH.
  - A beat that has both s_tlast=1 and count=MAX_PKT_WORDS is a normal packet end with no err_trunc.
- FLUSH:
  - s_tready[grant_ch]=1 and beats are discarded; the output register is not loaded.
  - On an accepted s_tlast, go to IDLE.
- channel_up:
  - channel_up only gates grants in IDLE.
  - A packet already granted finishes through DATA/FLUSH even if channel_up drops.
- A channel going invalid mid-packet stalls the mux in DATA; there is no timeout.
- Only one channel is ever granted; no bubbles are inserted between packets beyond the IDLE grant cycle.
- Reset asserted mid-packet: all state returns to reset values on the next edge, and partial packets are abandoned.

Optional Feature:
- Macro: GTP_TX_MUX_TRAILER_EN.
- Defined:
  - The last payload word (natural or truncated) carries m_tlast=0.
  - The FSM then enters a TRL state and, when out_free, emits one trailer word = {8'h5A, 7'b0, trunc_flag, payload word count zero-extended into the low bits} with m_tlast=1.
  - From TRL the FSM goes to IDLE, or to FLUSH if truncated.
  - Packet length on the wire = payload + 2 words.
- Not defined: the TRL state and trailer logic are absent, and the behaviour is exactly as above.

Test Plan:
- Single packet: ch2 sends 3 words 0x11,0x22,0x33 with tlast on 0x33, channel_up=1, m_tready=1 → output A5020000, 0x11, 0x22, 0x33; m_tlast only on 0x33; header appears 1 cycle after grant.
- Round-robin: all 4 channels continuously valid with 2-word packets → grant order 0,1,2,3,0; every packet is preceded by its header; no interleaving.
- Truncation: MAX_PKT_WORDS=4, ch1 sends 6 words → 4 payload words out with m_tlast on word 4; err_trunc high for exactly 1 cycle; words 5–6 consumed and dropped; next grant proceeds normally.
- Backpressure: m_tready toggles 1010… during a 5-word packet → m_tdata/m_tlast stable while stalled; all 6 words delivered in order; no loss or duplication.
- Link gating and reset: channel_up=0 with ch0 valid → no s_tready, m_tvalid stays 0; raise channel_up → packet flows. Assert reset mid-DATA → next cycle m_tvalid=0, s_tready=0, state IDLE.
- Trailer (GTP_TX_MUX_TRAILER_EN): 3-word packet on ch3 → A5030000, 3 payload words, then trailer 0x5A000003 with m_tlast; truncated case sets trunc_flag (bit 16 for DATA_W=32).
